// File: rtl/wbr_pkg.sv
// Shared types and constants for the IEEE 1500 wrapper boundary register.
package wbr_pkg;

  typedef enum logic [1:0] {
    WBR_HOLD,
    WBR_SHIFT,
    WBR_CAPTURE,
    WBR_TRANSFER
  } wbr_op_e;

  localparam int WBR_CNT_W = 16;

  // Shift wins over capture, capture over transfer; update is decoded separately.
  function automatic wbr_op_e wbr_decode(input logic shift, input logic capture,
                                         input logic transfer);
    if (shift) return WBR_SHIFT;
    if (capture) return WBR_CAPTURE;
    if (transfer) return WBR_TRANSFER;
    return WBR_HOLD;
  endfunction

endpackage

// File: rtl/wbr_cell_gen.sv
// One boundary cell: shift flop, optional update flop and the cfo output mux.
module wbr_cell_gen
  import wbr_pkg::*;
#(
  parameter int   UPDATE_STAGE = 1,
  parameter logic SAFE_BIT     = 1'b0,
  parameter logic CAPTURE_EN   = 1'b1
) (
  input  logic    clk,
  input  logic    arst,
  input  wbr_op_e op,
  input  logic    update,
  input  logic    ser_in,
  input  logic    cfi,
  input  logic    mode,
  input  logic    safe,
  output logic    sr_q,
  output logic    cfo
);

  logic r_sr;
  logic w_ur;

  if (UPDATE_STAGE != 0) begin : g_ur
    logic r_ur;
    always_ff @(posedge clk or posedge arst) begin
      if (arst) r_ur <= SAFE_BIT;
      else if (update) r_ur <= r_sr;
    end
    assign w_ur = r_ur;
  end else begin : g_no_ur
    // Without an update flop, test mode drives straight from the shift stage
    // and transfer reloads the cell with itself.
    logic w_unused_update;
    assign w_unused_update = update;
    assign w_ur = r_sr;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sr <= 1'b0;
    end else begin
      case (op)
        WBR_SHIFT:    r_sr <= ser_in;
        WBR_CAPTURE:  if (CAPTURE_EN) r_sr <= cfi;
        WBR_TRANSFER: r_sr <= w_ur;
        default:      r_sr <= r_sr;
      endcase
    end
  end

  assign sr_q = r_sr;
  assign cfo  = safe ? SAFE_BIT : (mode ? w_ur : cfi);

endmodule

// File: rtl/wbr_chain.sv
// Wrapper boundary register: WIDTH cells in one serial chain from wsi to wso,
// with shared op decode and a saturating shift counter for length checks.
module wbr_chain
  import wbr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               UPDATE_STAGE = 1,
  parameter logic [WIDTH-1:0] SAFE_VALUE   = '0,
  parameter logic [WIDTH-1:0] CAPTURE_MASK = '1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 wsi,
  output logic                 wso,
  input  logic [WIDTH-1:0]     cfi,
  output logic [WIDTH-1:0]     cfo,
  input  logic                 shift,
  input  logic                 capture,
  input  logic                 transfer,
  input  logic                 update,
  input  logic                 mode,
  input  logic                 safe,
  output logic [WBR_CNT_W-1:0] shift_cnt
);

  wbr_op_e              w_op;
  logic [WIDTH:0]       w_chain;
  logic [WBR_CNT_W-1:0] r_shift_cnt;

  assign w_op           = wbr_decode(shift, capture, transfer);
  assign w_chain[WIDTH] = wsi;
  assign wso            = w_chain[0];
  assign shift_cnt      = r_shift_cnt;

  // Cell i shifts in from cell i+1; the top cell takes wsi.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    wbr_cell_gen #(
      .UPDATE_STAGE(UPDATE_STAGE),
      .SAFE_BIT    (SAFE_VALUE[i]),
      .CAPTURE_EN  (CAPTURE_MASK[i])
    ) u_cell (
      .clk   (clk),
      .arst  (arst),
      .op    (w_op),
      .update(update),
      .ser_in(w_chain[i+1]),
      .cfi   (cfi[i]),
      .mode  (mode),
      .safe  (safe),
      .sr_q  (w_chain[i]),
      .cfo   (cfo[i])
    );
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_shift_cnt <= '0;
    end else begin
      case (w_op)
        WBR_SHIFT:
          if (r_shift_cnt != '1) r_shift_cnt <= r_shift_cnt + WBR_CNT_W'(1);
        WBR_CAPTURE, WBR_TRANSFER: r_shift_cnt <= '0;
        default: r_shift_cnt <= r_shift_cnt;
      endcase
    end
  end

endmodule
